// File: rtl/tempsens_sequencer.sv
// Ring-oscillator temperature sensor sequencer: gates the oscillator, averages
// 2^NAVG_LOG2 samples and ships the result over a UART. Optional header byte: TEMPSENS_HDR_EN.
module tempsens_sequencer #(
  parameter int WIDTH     = 16,
  parameter int WINDOW    = 1000,
  parameter int NAVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] count,
  input  logic             tx_busy,
  output logic             osc_en,
  output logic             cnt_clr,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic [2:0]       dbg_state
);
  // UART handshake: a byte is issued with a one-cycle tx_start (data held in
  // tx_data until the next issue); the UART acknowledges by raising tx_busy and
  // signals completion by dropping it. A new issue only happens with tx_busy low.

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_ACCUM, S_SEND, S_WAIT_HI, S_WAIT_LO
  } state_t;

  localparam int AW = WIDTH + NAVG_LOG2;
  localparam int IW = NAVG_LOG2 + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'((1 << NAVG_LOG2) - 1);
  localparam logic [15:0]   WIN_LOAD = 16'(WINDOW - 1);
`ifdef TEMPSENS_HDR_EN
  localparam logic [1:0]    LAST_BYTE = 2'd2;
`else
  localparam logic [1:0]    LAST_BYTE = 2'd1;
`endif

  state_t           state_q, state_d;
  logic [15:0]      gate_cnt_q, gate_cnt_d;
  logic             settle_q, settle_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       byte_ptr_q, byte_ptr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic [AW-1:0]    acc_sum;
  logic [15:0]      res16;
  logic [7:0]       byte_sel;

  always_comb begin
    res16 = 16'(result_q);
`ifdef TEMPSENS_HDR_EN
    case (byte_ptr_q)
      2'd0:    byte_sel = 8'hA5;
      2'd1:    byte_sel = res16[7:0];
      default: byte_sel = res16[15:8];
    endcase
`else
    byte_sel = (byte_ptr_q == 2'd0) ? res16[7:0] : res16[15:8];
`endif
  end

  assign acc_sum = acc_q + AW'(count);

  always_comb begin
    state_d        = state_q;
    gate_cnt_d     = gate_cnt_q;
    settle_d       = settle_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    byte_ptr_d     = byte_ptr_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        gate_cnt_d = WIN_LOAD;
        state_d    = S_GATE;
      end
      S_GATE: begin
        if (gate_cnt_q == 16'd0) begin
          settle_d = 1'b1;
          state_d  = S_SETTLE;
        end else begin
          gate_cnt_d = gate_cnt_q - 16'd1;
        end
      end
      S_SETTLE: begin
        // Two dead cycles so the asynchronous counter is stable before sampling.
        if (settle_q) settle_d = 1'b0;
        else          state_d  = S_ACCUM;
      end
      S_ACCUM: begin
        acc_d = acc_sum;
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + IW'(1);
          state_d = S_CLEAR;
        end else begin
          result_d       = WIDTH'(acc_sum >> NAVG_LOG2);
          result_valid_d = 1'b1;
          byte_ptr_d     = 2'd0;
          state_d        = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = byte_sel;
          state_d    = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (tx_busy) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (byte_ptr_q == LAST_BYTE) begin
            state_d = S_IDLE;
          end else begin
            byte_ptr_d = byte_ptr_q + 2'd1;
            state_d    = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      gate_cnt_q     <= '0;
      settle_q       <= 1'b0;
      acc_q          <= '0;
      idx_q          <= '0;
      byte_ptr_q     <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      gate_cnt_q     <= gate_cnt_d;
      settle_q       <= settle_d;
      acc_q          <= acc_d;
      idx_q          <= idx_d;
      byte_ptr_q     <= byte_ptr_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
    end
  end

  // Gate and clear decode straight from the state so reset kills osc_en at once.
  assign osc_en       = (state_q == S_GATE);
  assign cnt_clr      = (state_q == S_CLEAR);
  assign busy         = (state_q != S_IDLE);
  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_tempsens_sequencer.sv
// Directed bench for tempsens_sequencer: two instances (WINDOW=10/NAVG_LOG2=2 and
// WINDOW=3/NAVG_LOG2=4) share stimulus through a select; expected bytes follow TEMPSENS_HDR_EN.
module tb_tempsens_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, tx_busy, sel;
  logic [15:0] count;

  logic        osc_a, clr_a, txs_a, rv_a, busy_a;
  logic [7:0]  txd_a;
  logic [15:0] res_a;
  logic [2:0]  dbg_a;
  logic        osc_b, clr_b, txs_b, rv_b, busy_b;
  logic [7:0]  txd_b;
  logic [15:0] res_b;
  logic [2:0]  dbg_b;

  logic        start_a, start_b;
  logic        osc_m, clr_m, txs_m, rv_m, busy_m;
  logic [7:0]  txd_m;
  logic [15:0] res_m;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign osc_m   = sel ? osc_b  : osc_a;
  assign clr_m   = sel ? clr_b  : clr_a;
  assign txs_m   = sel ? txs_b  : txs_a;
  assign rv_m    = sel ? rv_b   : rv_a;
  assign busy_m  = sel ? busy_b : busy_a;
  assign txd_m   = sel ? txd_b  : txd_a;
  assign res_m   = sel ? res_b  : res_a;

  tempsens_sequencer #(.WIDTH(16), .WINDOW(10), .NAVG_LOG2(2)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .count(count), .tx_busy(tx_busy),
    .osc_en(osc_a), .cnt_clr(clr_a), .tx_start(txs_a), .tx_data(txd_a),
    .result(res_a), .result_valid(rv_a), .busy(busy_a), .dbg_state(dbg_a)
  );

  tempsens_sequencer #(.WIDTH(16), .WINDOW(3), .NAVG_LOG2(4)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .count(count), .tx_busy(tx_busy),
    .osc_en(osc_b), .cnt_clr(clr_b), .tx_start(txs_b), .tx_data(txd_b),
    .result(res_b), .result_valid(rv_b), .busy(busy_b), .dbg_state(dbg_b)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [15:0] cnt_tab[16];

  int          clr_pulses, clr_first, runs, bad_runs, bad_gaps, valid_pulses;
  int          tx_pulses, early_tx, tx_delay, timeout, idle_activity;
  logic [15:0] res_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_expected(input logic [15:0] r);
    exp_q.delete();
`ifdef TEMPSENS_HDR_EN
    exp_q.push_back(8'hA5);
`endif
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
  endtask

  // One complete measurement frame on the selected instance, acting as the UART.
  task automatic run_frame(input int stall, input int win, input int budget);
    int   cyc, run, low, stall_left, busy_left, valid_cyc;
    logic prev_osc, done;
    clr_pulses = 0; clr_first = -1; runs = 0; bad_runs = 0; bad_gaps = 0;
    valid_pulses = 0; tx_pulses = 0; early_tx = 0; tx_delay = -1; timeout = 0;
    res_seen = 16'h0; got_q.delete();
    cyc = 0; run = 0; low = 0; stall_left = 0; busy_left = 0; valid_cyc = 0;
    prev_osc = 1'b0; done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    while (!done) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 3);  // stray request while gating must be dropped
      if (clr_m) begin
        if (runs > 0 && low != 3) bad_gaps++;
        clr_pulses++;
        if (clr_first < 0) clr_first = cyc;
        count = cnt_tab[(clr_pulses - 1) % 16];
      end
      if (rv_m) begin
        if (low != 3) bad_gaps++;
        valid_pulses++;
        res_seen  = res_m;
        valid_cyc = cyc;
        if (stall > 0) begin
          stall_left = stall;
          tx_busy    = 1'b1;
        end
      end
      if (osc_m) begin
        run++;
        low = 0;
      end else if (prev_osc) begin
        runs++;
        if (run != win) bad_runs++;
        run = 0;
        low = 1;
      end else begin
        low++;
      end
      prev_osc = osc_m;
      if (txs_m) begin
        tx_pulses++;
        if (stall_left > 0) early_tx++;
        if (tx_delay < 0) tx_delay = cyc - valid_cyc;
        got_q.push_back(txd_m);
        tx_busy   = 1'b1;
        busy_left = 3;
      end else if (stall_left > 0 && !rv_m) begin
        stall_left--;
        if (stall_left == 0) tx_busy = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
      if (got_q.size() >= exp_q.size() && !busy_m && tx_pulses > 0) done = 1'b1;
      if (cyc >= budget) begin
        timeout = 1;
        done    = 1'b1;
      end
    end
    start   = 1'b0;
    tx_busy = 1'b0;
    idle_activity = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy_m || clr_m || osc_m) idle_activity++;
    end
  endtask

  task automatic check_frame(input string tag, input int nsamp, input logic [15:0] r, input int delay);
    int n;
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_clr_pulses"}, clr_pulses, nsamp);
    check({tag, "_clr_first"}, clr_first, 1);
    check({tag, "_gate_runs"}, runs, nsamp);
    check({tag, "_gate_len_bad"}, bad_runs, 0);
    check({tag, "_settle_gap_bad"}, bad_gaps, 0);
    check({tag, "_valid_pulses"}, valid_pulses, 1);
    check({tag, "_result_pulse"}, res_seen, r);
    check({tag, "_result_held"}, res_m, r);
    check({tag, "_tx_delay"}, tx_delay, delay);
    check({tag, "_tx_early"}, early_tx, 0);
    check({tag, "_tx_pulses"}, tx_pulses, exp_q.size());
    check({tag, "_idle_after"}, idle_activity, 0);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
      else                  check($sformatf("%s_byte%0d_missing", tag, i), 32'hFFFF_FFFF, exp_q[i]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tx_busy = 1'b0; sel = 1'b0; count = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_osc_en", osc_a, 0);
    check("rst_cnt_clr", clr_a, 0);
    check("rst_tx_start", txs_a, 0);
    check("rst_tx_data", txd_a, 0);
    check("rst_result", res_a, 0);
    check("rst_result_valid", rv_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_busy_b", busy_b, 0);
    reset = 1'b0;
    @(negedge clk);

    // 100..103 average to 101 = 0x0065
    cnt_tab[0] = 16'd100; cnt_tab[1] = 16'd101; cnt_tab[2] = 16'd102; cnt_tab[3] = 16'd103;
    set_expected(16'h0065);
    run_frame(0, 10, 400);
    check_frame("avg", 4, 16'h0065, 1);

    // UART busy for 50 cycles on entry to SEND; 7,8,9,10 -> 34>>2 = 8
    cnt_tab[0] = 16'd7; cnt_tab[1] = 16'd8; cnt_tab[2] = 16'd9; cnt_tab[3] = 16'd10;
    set_expected(16'h0008);
    run_frame(50, 10, 600);
    check_frame("stall", 4, 16'h0008, 51);

    // 16 samples of full-scale count: no accumulator overflow
    sel = 1'b1;
    for (int i = 0; i < 16; i++) cnt_tab[i] = 16'hFFFF;
    set_expected(16'hFFFF);
    run_frame(0, 3, 600);
    check_frame("fullscale", 16, 16'hFFFF, 1);
    sel = 1'b0;

    // Reset in the middle of the gate window
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midgate_osc_before", osc_a, 1);
    #2 reset = 1'b1;
    #1;
    check("midgate_osc_async", osc_a, 0);
    check("midgate_busy", busy_a, 0);
    check("midgate_cnt_clr", clr_a, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midgate_result_cleared", res_a, 0);

    // Fresh start after the abort takes all four samples: 101>>2 = 25
    cnt_tab[0] = 16'd10; cnt_tab[1] = 16'd20; cnt_tab[2] = 16'd30; cnt_tab[3] = 16'd41;
    set_expected(16'h0019);
    run_frame(0, 10, 400);
    check_frame("restart", 4, 16'h0019, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tempsens_sequencer.md
TEMPSENS_SEQUENCER -- requirements
Module: tempsens_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: ring-oscillator counter width.
REQ-002 SHALL have parameter WINDOW, default 1000: gate length in clk cycles (range 1..65535).
REQ-003 SHALL have parameter NAVG_LOG2, default 2: log2 of samples averaged per measurement (range 0..4).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle measurement request.
REQ-007 SHALL have port count  input  WIDTH  oscillator counter value, sampled only in ACCUM.
REQ-008 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-009 SHALL have port osc_en  output  1  oscillator/counter enable gate.
REQ-010 SHALL have port cnt_clr  output  1  counter clear pulse.
REQ-011 SHALL have port tx_start  output  1  one-cycle UART send strobe.
REQ-012 SHALL have port tx_data  output  8  byte presented with tx_start, held until next tx_start.
REQ-013 SHALL have port result  output  WIDTH  last averaged measurement.
REQ-014 SHALL have port result_valid  output  1  one-cycle pulse when result updates.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, GATE, SETTLE, ACCUM, SEND, WAIT_HI, WAIT_LO.
REQ-017 SHALL leave IDLE for CLEAR on the first cycle start=1; start outside IDLE SHALL be ignored (no queuing).
REQ-018 SHALL assert cnt_clr for exactly one cycle in CLEAR, then enter GATE.
REQ-019 SHALL assert osc_en for exactly WINDOW consecutive cycles in GATE, via a down-counter loaded with WINDOW-1.
REQ-020 SHALL hold osc_en low for exactly 2 cycles in SETTLE before ACCUM, letting the asynchronous counter settle.
REQ-021 SHALL add count, zero-extended, to a WIDTH+NAVG_LOG2-bit accumulator in ACCUM; the sum never overflows.
REQ-022 SHALL clear the accumulator and sample index on the IDLE->CLEAR transition only.
REQ-023 SHALL go ACCUM->CLEAR while the sample index is below 2^NAVG_LOG2-1; otherwise go to SEND.
REQ-024 SHALL, on the final ACCUM, register result = accumulator (including the current sample) >> NAVG_LOG2 (truncating) and pulse result_valid in that same cycle's next edge.
REQ-025 SHALL send bytes in order result[7:0], then result[15:8]; WIDTH<16 SHALL zero-pad the high byte.
REQ-026 SHALL, in SEND, pulse tx_start only when tx_busy=0, then enter WAIT_HI; tx_busy=1 in SEND stalls.
REQ-027 SHALL leave WAIT_HI when tx_busy=1 and WAIT_LO when tx_busy=0; after the last byte it SHALL return to IDLE, otherwise to SEND.
REQ-028 SHALL keep osc_en=0 in all states except GATE, and tx_start=0 except the SEND issue cycle.

Reset
REQ-029 SHALL force, while reset=1: state IDLE, osc_en=0, cnt_clr=0, tx_start=0, tx_data=0, result=0, result_valid=0, busy=0, accumulator, index and byte pointer 0.
REQ-030 SHALL abort any in-progress measurement or transmission on reset, dropping partial data; osc_en SHALL fall asynchronously.

Configuration
REQ-031 SHALL, with macro TEMPSENS_HDR_EN defined, send header byte 0xA5 before the two result bytes (3 bytes per frame); undefined, SHALL send only the 2 result bytes.

Verification
REQ-032 SHALL cover: WINDOW=10, NAVG_LOG2=2, counts 100,101,102,103 -> result=0x0065, one result_valid pulse, bytes 0x65,0x00.
REQ-033 SHALL cover: start pulse -> cnt_clr high 1 cycle, then osc_en high exactly 10 cycles, low 2 cycles before ACCUM.
REQ-034 SHALL cover: NAVG_LOG2=4, count fixed 0xFFFF -> result=0xFFFF, no overflow, bytes 0xFF,0xFF.
REQ-035 SHALL cover: tx_busy held high 50 cycles when entering SEND -> tx_start withheld until tx_busy=0, then one pulse.
REQ-036 SHALL cover: start during GATE ignored; reset mid-GATE -> osc_en=0 immediately, busy=0, next start restarts from sample 0.
REQ-037 SHALL cover: with TEMPSENS_HDR_EN defined, REQ-032 stimulus -> bytes 0xA5,0x65,0x00.
